// File: rtl/irq_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : irq_ctrl_pkg
// Description : Shared interrupt cause codes, mip bit positions, register map.
// Revision    : 1.0 - initial release
// ============================================================================
package irq_ctrl_pkg;

    typedef enum logic [4:0] {
        CAUSE_NONE = 5'd0,
        CAUSE_MSI  = 5'd3,
        CAUSE_MTI  = 5'd7,
        CAUSE_MEI  = 5'd11
    } ecause_t;

    localparam int unsigned c_mip_msip = 3;
    localparam int unsigned c_mip_mtip = 7;
    localparam int unsigned c_mip_meip = 11;

    // Register select is bus_addr[4:2]
    localparam logic [2:0] c_reg_msip    = 3'd0;
    localparam logic [2:0] c_reg_cmp_lo  = 3'd1;
    localparam logic [2:0] c_reg_cmp_hi  = 3'd2;
    localparam logic [2:0] c_reg_time_lo = 3'd3;
    localparam logic [2:0] c_reg_time_hi = 3'd4;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_REQ  = 1'b1
    } irq_state_t;

    // Fixed priority: external, then software, then timer
    function automatic ecause_t pick_cause(input logic [31:0] elig);
        if (elig[c_mip_meip])      return CAUSE_MEI;
        else if (elig[c_mip_msip]) return CAUSE_MSI;
        else if (elig[c_mip_mtip]) return CAUSE_MTI;
        else                       return CAUSE_NONE;
    endfunction

endpackage
`default_nettype wire

// File: rtl/irq_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : irq_ctrl_if
// Description : Memory-mapped register bus between a master and irq_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
interface irq_ctrl_if;
    logic        bus_req;
    logic        bus_we;
    logic [4:0]  bus_addr;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic        bus_ack;

    modport master (
        output bus_req, bus_we, bus_addr, bus_wdata,
        input  bus_rdata, bus_ack
    );

    modport slave (
        input  bus_req, bus_we, bus_addr, bus_wdata,
        output bus_rdata, bus_ack
    );
endinterface
`default_nettype wire

// File: rtl/irq_timer.sv
`default_nettype none
// ============================================================================
// Module      : irq_timer
// Description : 64-bit mtime/mtimecmp with tick prescaler and registered MTIP.
// Revision    : 1.0 - initial release
// ============================================================================
module irq_timer #(
    parameter int unsigned TICK_DIV = 1
) (
    input  wire logic        clk_core,
    input  wire logic        reset_n,
    input  wire logic        i_wr_cmp_lo,
    input  wire logic        i_wr_cmp_hi,
    input  wire logic        i_wr_time_lo,
    input  wire logic        i_wr_time_hi,
    input  wire logic [31:0] i_wdata,
    output logic      [63:0] o_mtime,
    output logic      [63:0] o_mtimecmp,
    output logic             o_mtip
);

    localparam logic [7:0] c_tick_last = 8'(TICK_DIV - 1);

    logic [7:0]  r_tick;
    logic [63:0] r_mtime;
    logic [63:0] r_mtimecmp;
    logic        r_mtip;
    logic        w_time_wr;
    logic        w_tick_wrap;

    assign w_time_wr   = i_wr_time_lo | i_wr_time_hi;
    assign w_tick_wrap = (r_tick == c_tick_last);

    always_ff @(posedge clk_core) begin
        if (!reset_n) begin
            r_tick     <= '0;
            r_mtime    <= '0;
            r_mtimecmp <= '1;
            r_mtip     <= 1'b0;
        end else begin
            r_mtip <= (r_mtime >= r_mtimecmp);
            // A software write replaces only its half and restarts the prescaler
            if (w_time_wr) begin
                r_tick <= '0;
                if (i_wr_time_lo) r_mtime[31:0]  <= i_wdata;
                if (i_wr_time_hi) r_mtime[63:32] <= i_wdata;
            end else if (w_tick_wrap) begin
                r_tick  <= '0;
                r_mtime <= r_mtime + 64'd1;
            end else begin
                r_tick <= r_tick + 8'd1;
            end
            if (i_wr_cmp_lo) r_mtimecmp[31:0]  <= i_wdata;
            if (i_wr_cmp_hi) r_mtimecmp[63:32] <= i_wdata;
        end
    end

    assign o_mtime    = r_mtime;
    assign o_mtimecmp = r_mtimecmp;
    assign o_mtip     = r_mtip;

endmodule
`default_nettype wire

// File: rtl/irq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : irq_ctrl
// Description : Machine interrupt controller: msip/timer registers, MEIP sync,
//               priority arbitration and request/ack handshake to writeback.
// Revision    : 1.0 - initial release
// ============================================================================
module irq_ctrl
    import irq_ctrl_pkg::*;
#(
    parameter int unsigned TICK_DIV = 1
) (
    input  wire logic        clk_core,
    input  wire logic        reset_n,
    irq_ctrl_if.slave        bus,
    input  wire logic        ext_irq,
    input  wire logic        csr_mstatus_mie,
    input  wire logic [31:0] csr_mie,
    output logic      [31:0] irq_mip,
    output logic             irq_req,
    output logic      [4:0]  irq_cause,
    input  wire logic        irq_ack
);

    logic        r_ack;
    logic [31:0] r_rdata;
    logic        r_msip;
    logic        r_sync1;
    logic        r_sync2;
    irq_state_t  r_state;
    irq_state_t  w_state_nxt;
    ecause_t     r_cause;
    ecause_t     w_cause_nxt;

    logic        w_access;
    logic        w_wr;
    logic [2:0]  w_sel;
    logic [31:0] w_rmux;
    logic [31:0] w_elig;
    logic [63:0] w_mtime;
    logic [63:0] w_mtimecmp;
    logic        w_mtip;
    logic        w_unused_addr;

    // The ack cycle never starts a new access even if bus_req is still high
    assign w_access      = bus.bus_req & ~r_ack;
    assign w_wr          = w_access & bus.bus_we;
    assign w_sel         = bus.bus_addr[4:2];
    assign w_unused_addr = ^bus.bus_addr[1:0];

    irq_timer #(
        .TICK_DIV (TICK_DIV)
    ) u_timer (
        .clk_core     (clk_core),
        .reset_n      (reset_n),
        .i_wr_cmp_lo  (w_wr && (w_sel == c_reg_cmp_lo)),
        .i_wr_cmp_hi  (w_wr && (w_sel == c_reg_cmp_hi)),
        .i_wr_time_lo (w_wr && (w_sel == c_reg_time_lo)),
        .i_wr_time_hi (w_wr && (w_sel == c_reg_time_hi)),
        .i_wdata      (bus.bus_wdata),
        .o_mtime      (w_mtime),
        .o_mtimecmp   (w_mtimecmp),
        .o_mtip       (w_mtip)
    );

    always_comb begin
        w_rmux = '0;
        case (w_sel)
            c_reg_msip:    w_rmux = {31'd0, r_msip};
            c_reg_cmp_lo:  w_rmux = w_mtimecmp[31:0];
            c_reg_cmp_hi:  w_rmux = w_mtimecmp[63:32];
            c_reg_time_lo: w_rmux = w_mtime[31:0];
            c_reg_time_hi: w_rmux = w_mtime[63:32];
            default:       w_rmux = '0;
        endcase
    end

    always_ff @(posedge clk_core) begin
        if (!reset_n) begin
            r_ack   <= 1'b0;
            r_rdata <= '0;
            r_msip  <= 1'b0;
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_ack   <= w_access;
            r_rdata <= (w_access && !bus.bus_we) ? w_rmux : '0;
            if (w_wr && (w_sel == c_reg_msip)) r_msip <= bus.bus_wdata[0];
            r_sync1 <= ext_irq;
            r_sync2 <= r_sync1;
        end
    end

    assign bus.bus_ack   = r_ack;
    assign bus.bus_rdata = r_rdata;

    always_comb begin
        irq_mip             = '0;
        irq_mip[c_mip_msip] = r_msip;
        irq_mip[c_mip_mtip] = w_mtip;
        irq_mip[c_mip_meip] = r_sync2;
    end

    assign w_elig = irq_mip & csr_mie & {32{csr_mstatus_mie}};

    always_ff @(posedge clk_core) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
            r_cause <= CAUSE_NONE;
        end else begin
            r_state <= w_state_nxt;
            r_cause <= w_cause_nxt;
        end
    end

    // Cause is latched once per request; withdrawal or ack both return to IDLE
    always_comb begin
        w_state_nxt = r_state;
        w_cause_nxt = r_cause;
        case (r_state)
            ST_IDLE: begin
                if (|w_elig) begin
                    w_state_nxt = ST_REQ;
                    w_cause_nxt = pick_cause(w_elig);
                end
            end
            ST_REQ: begin
                if (irq_ack || !w_elig[r_cause]) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign irq_req   = (r_state == ST_REQ);
    assign irq_cause = r_cause;

endmodule
`default_nettype wire

// File: doc/irq_ctrl.md
IRQ_CTRL -- requirements
Module: irq_ctrl

Interface
REQ-001 Parameter: TICK_DIV, default 1, mtime increments once every TICK_DIV clk_core cycles; legal range 1..255.
REQ-002 clk_core  input  1  core clock; all state updates on its rising edge.
REQ-003 reset_n  input  1  synchronous, active-low reset.
REQ-004 bus_req  input  1  memory-mapped register access request; held high until bus_ack.
REQ-005 bus_we  input  1  1 = write, 0 = read; valid with bus_req.
REQ-006 bus_addr  input  5  byte offset; bits [4:2] select the register, bits [1:0] are ignored.
REQ-007 bus_wdata  input  32  write data.
REQ-008 bus_rdata  output  32  read data; valid while bus_ack is high.
REQ-009 bus_ack  output  1  one-cycle access completion pulse.
REQ-010 ext_irq  input  1  asynchronous, level-sensitive external interrupt.
REQ-011 csr_mstatus_mie  input  1  global machine interrupt enable, from the CSR unit.
REQ-012 csr_mie  input  32  machine interrupt-enable CSR; only bits 3, 7 and 11 are used.
REQ-013 irq_mip  output  32  mip view for CSR reads; bit 3 = MSIP, bit 7 = MTIP, bit 11 = MEIP, all other bits are 0.
REQ-014 irq_req  output  1  interrupt request to writeback.
REQ-015 irq_cause  output  5  cause code of the requested interrupt: 3, 7 or 11.
REQ-016 irq_ack  input  1  writeback has taken the trap for the presented irq_cause.

Function
REQ-017 Register map by bus_addr[4:2]:
- 0 = msip; only bit 0 is writable.
- 1 = mtimecmp[31:0].
- 2 = mtimecmp[63:32].
- 3 = mtime[31:0].
- 4 = mtime[63:32].
- 5..7 read as 0; writes to them are ignored.
REQ-018 An access SHALL complete with bus_ack high exactly one cycle after bus_req is first sampled high; bus_rdata SHALL be registered; no new access is accepted in the ack cycle.
REQ-019 A tick counter SHALL count 0..TICK_DIV-1; mtime SHALL increment by 1 when the counter wraps, and 64-bit mtime SHALL wrap from 2^64-1 to 0.
REQ-020 A bus write to either mtime half SHALL take priority over an increment in the same cycle; the other half SHALL be unchanged (no carry); the tick counter SHALL clear on the write.
REQ-021 MTIP SHALL be registered from the unsigned 64-bit comparison mtime >= mtimecmp and updated every cycle.
REQ-022 MEIP SHALL be ext_irq passed through a 2-flop synchronizer (2-cycle latency).
REQ-023 MSIP SHALL be msip[0].
REQ-024 Eligible set = irq_mip & csr_mie, gated by csr_mstatus_mie; priority order is MEI(11), then MSI(3), then MTI(7).
REQ-025 The FSM SHALL have two states, IDLE and REQ:
- IDLE to REQ when the eligible set is non-zero; the winner's cause is latched into irq_cause.
- In REQ, irq_req is 1 and irq_cause is held stable; there is no re-arbitration.
REQ-026 REQ to IDLE on irq_ack; irq_req SHALL be 0 in the following cycle, and re-arbitration SHALL not occur earlier than one cycle after the ack.
REQ-027 REQ to IDLE also when the latched source is no longer eligible (deasserted, masked, or csr_mstatus_mie=0) before ack.
REQ-028 If irq_ack and loss of eligibility occur in the same cycle, ack SHALL take effect.
REQ-029 irq_ack while in IDLE SHALL be ignored.

Reset
REQ-030 On reset_n=0 at a rising edge, the following SHALL reset:
- msip=0, mtime=0, mtimecmp=64'hFFFF_FFFF_FFFF_FFFF, tick counter=0.
- synchronizer flops=0, MTIP=0.
- FSM=IDLE, irq_req=0, irq_cause=0, bus_ack=0, bus_rdata=0.
REQ-031 Reset during an outstanding request or bus access SHALL abandon it; no bus_ack is produced for an access in flight at reset.

Structure
REQ-032 Cause codes (MSI=3, MTI=7, MEI=11), mip bit positions and register offsets SHALL live in the shared core package beside ecause_t.
REQ-033 The 64-bit mtime/mtimecmp timer with its tick counter SHALL be a sub-module named irq_timer; arbitration, FSM and bus decode stay in irq_ctrl.

Verification
REQ-034 Timer interrupt: TICK_DIV=1, write mtimecmp hi=0 then lo=10, mie bit 7=1, mstatus_mie=1 -> irq_req rises with cause 7 once mtime reaches 10 (+1 cycle for MTIP register); irq_ack -> irq_req=0 the next cycle.
REQ-035 Priority: MSIP, MTIP and MEIP all pending and enabled -> cause 11; after ack and MEIP cleared -> cause 3; after msip=0 -> cause 7.
REQ-036 Withdrawal: in REQ with cause 11, drop ext_irq -> irq_req=0 three cycles later; ext_irq drop coincident with ack -> ack honored, no glitch.
REQ-037 Wrap and write collision: mtime=64'hFFFF_FFFF_FFFF_FFFF -> 0 next tick; write mtime lo=5 in an increment cycle -> mtime lo=5 with hi unchanged.
REQ-038 Bus: read offset 0x14 -> rdata=0 with ack after 1 cycle; write to 0x1C ignored; reset asserted mid-REQ -> irq_req=0 and mtimecmp=all ones.
